// File: rtl/ir_fetch_stage.sv
// ir_fetch_stage: first instruction pipeline stage.
// It holds the program counter and drives the instruction-memory address.
// It registers each fetched word, together with its PC, into the next IR stage.
// The same block contains the debugger run-control FSM (halt / resume / single-step).
// When there is no real instruction, it injects the NOP_INSTR bubble.
//
// Optional feature, macro DBG_PC_WRITE_EN:
//   adds the ports dbg_pc_we and dbg_pc_wdata, so the debugger can rewrite
//   the PC while the core is halted.
//
// State | meaning
// ------+------------------------------------------------------------
// RUN   | normal fetching; a halt request stops fetch when not stalled
// HALT  | no fetch, bubbles issued, debugger owns the PC
// STEP  | exactly one fetch (or redirect) cycle, then back to HALT

module ir_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_stages,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  input  logic        dbg_halt_req,
  input  logic        dbg_resume_req,
  input  logic        dbg_step_req,
`ifdef DBG_PC_WRITE_EN
  input  logic        dbg_pc_we,
  input  logic [31:0] dbg_pc_wdata,
`endif
  output logic [31:0] imem_addr,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic        ir_valid,
  output logic        dbg_halted,
  output logic [31:0] dbg_pc
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;

  // Address and debug PC both expose the live program counter
  assign imem_addr    = pc_reg;
  assign dbg_pc       = pc_reg;
  assign pc_plus4     = pc_reg + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Run-control FSM together with the PC and the IR registers
  always_ff @(posedge clk) begin
    if (reset_stages) begin
      state      <= ST_RUN;
      pc_reg     <= RESET_PC;
      ir_out     <= NOP_INSTR;
      pc_out     <= RESET_PC;
      ir_valid   <= 1'b0;
      dbg_halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect_valid) begin
            pc_reg   <= redirect_tgt;
            ir_out   <= NOP_INSTR;
            ir_valid <= 1'b0;
          end else if (!stall) begin
            if (dbg_halt_req) begin
              ir_out   <= NOP_INSTR;
              ir_valid <= 1'b0;
            end else begin
              ir_out   <= imem_rdata;
              pc_out   <= pc_reg;
              ir_valid <= 1'b1;
              pc_reg   <= pc_plus4;
            end
          end
          // A halt under stall waits; a simultaneous redirect still lands first
          if (dbg_halt_req && !stall) begin
            state      <= ST_HALTED;
            dbg_halted <= 1'b1;
          end
        end

        ST_HALTED: begin
          if (redirect_valid) begin
            pc_reg   <= redirect_tgt;
            ir_out   <= NOP_INSTR;
            ir_valid <= 1'b0;
          end else begin
`ifdef DBG_PC_WRITE_EN
            if (dbg_pc_we) begin
              pc_reg <= {dbg_pc_wdata[31:2], 2'b00};
            end
`endif
            // A stepped instruction stays put until downstream takes it
            if (!stall) begin
              ir_out   <= NOP_INSTR;
              ir_valid <= 1'b0;
            end
          end
          if (dbg_resume_req) begin
            state      <= ST_RUN;
            dbg_halted <= 1'b0;
          end else if (dbg_step_req) begin
            state      <= ST_STEP;
            dbg_halted <= 1'b0;
          end
        end

        ST_STEP: begin
          if (redirect_valid) begin
            pc_reg     <= redirect_tgt;
            ir_out     <= NOP_INSTR;
            ir_valid   <= 1'b0;
            state      <= ST_HALTED;
            dbg_halted <= 1'b1;
          end else if (!stall) begin
            ir_out     <= imem_rdata;
            pc_out     <= pc_reg;
            ir_valid   <= 1'b1;
            pc_reg     <= pc_plus4;
            state      <= ST_HALTED;
            dbg_halted <= 1'b1;
          end
        end

        default: begin
          state      <= ST_RUN;
          dbg_halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_stage.sv
module tb_ir_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_stages;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        dbg_step_req;
  logic        dbg_pc_we;
  logic [31:0] dbg_pc_wdata;
  logic [31:0] imem_addr;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        ir_valid;
  logic        dbg_halted;
  logic [31:0] dbg_pc;

  int errors = 0;
  int checks = 0;

  ir_fetch_stage dut (
    .clk            (clk),
    .reset_stages   (reset_stages),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rdata     (imem_rdata),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_step_req   (dbg_step_req),
`ifdef DBG_PC_WRITE_EN
    .dbg_pc_we      (dbg_pc_we),
    .dbg_pc_wdata   (dbg_pc_wdata),
`endif
    .imem_addr      (imem_addr),
    .ir_out         (ir_out),
    .pc_out         (pc_out),
    .ir_valid       (ir_valid),
    .dbg_halted     (dbg_halted),
    .dbg_pc         (dbg_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0F13;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_stages   = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dbg_halt_req   = 1'b0;
    dbg_resume_req = 1'b0;
    dbg_step_req   = 1'b0;
    dbg_pc_we      = 1'b0;
    dbg_pc_wdata   = 32'h0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_ir, input logic [31:0] e_pco,
                         input logic e_v, input logic [31:0] e_addr, input logic e_h);
    chk({tag, ".ir_out"}, ir_out, e_ir);
    chk({tag, ".pc_out"}, pc_out, e_pco);
    chk({tag, ".ir_valid"}, {31'b0, ir_valid}, {31'b0, e_v});
    chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk({tag, ".dbg_pc"}, dbg_pc, e_addr);
    chk({tag, ".dbg_halted"}, {31'b0, dbg_halted}, {31'b0, e_h});
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdv;
    logic [31:0] rpc;
    logic        hlt;
    logic [31:0] e_ir;
    logic [31:0] e_pco;
    logic        e_v;
    logic [31:0] e_addr;
    logic        e_h;
  } vec_t;

  vec_t tbl[10];

  // Reference model: per-cycle effect, derived from the architectural rules
  logic [31:0] m_pc, m_ir, m_pco;
  logic        m_v;
  int          m_mode;  // 0 running, 1 halted, 2 single-stepping

  task automatic model_step(input logic we, input logic [31:0] wd);
    bit fetch_now;
    int next_mode;
    if (reset_stages) begin
      m_pc = 32'h0; m_ir = NOP; m_pco = 32'h0; m_v = 1'b0; m_mode = 0;
      return;
    end
    fetch_now = (m_mode != 1) && !stall && !redirect_valid && !(m_mode == 0 && dbg_halt_req);
    next_mode = m_mode;
    if (m_mode == 0 && dbg_halt_req && !stall) next_mode = 1;
    if (m_mode == 1) begin
      if (dbg_resume_req) next_mode = 0;
      else if (dbg_step_req) next_mode = 2;
    end
    if (m_mode == 2 && (redirect_valid || !stall)) next_mode = 1;
    if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3;
      m_ir = NOP;
      m_v  = 1'b0;
    end else if (fetch_now) begin
      m_ir  = mem(m_pc);
      m_pco = m_pc;
      m_v   = 1'b1;
      m_pc  = m_pc + 32'd4;
    end else begin
      if (m_mode == 1 && we) m_pc = wd & ~32'h3;
      if (!stall) begin
        m_ir = NOP;
        m_v  = 1'b0;
      end
    end
    m_mode = next_mode;
  endtask

  initial begin
    int vcount;
    idle();

    // Table: reset, first fetches, stall hold, redirect under stall
    tbl[0] = '{1, 0, 0, 32'h0,   0, NOP,             32'h0,  0, 32'h0,   0};
    tbl[1] = '{0, 0, 0, 32'h0,   0, 32'h0050_0093,   32'h0,  1, 32'h4,   0};
    tbl[2] = '{0, 0, 0, 32'h0,   0, 32'h0010_0113,   32'h4,  1, 32'h8,   0};
    tbl[3] = '{0, 0, 1, 32'hC,   0, NOP,             32'h4,  0, 32'hC,   0};
    tbl[4] = '{0, 0, 0, 32'h0,   0, mem(32'hC),      32'hC,  1, 32'h10,  0};
    tbl[5] = '{0, 1, 0, 32'h0,   0, mem(32'hC),      32'hC,  1, 32'h10,  0};
    tbl[6] = '{0, 1, 0, 32'h0,   1, mem(32'hC),      32'hC,  1, 32'h10,  0};
    tbl[7] = '{0, 1, 0, 32'h0,   0, mem(32'hC),      32'hC,  1, 32'h10,  0};
    tbl[8] = '{0, 0, 0, 32'h0,   0, mem(32'h10),     32'h10, 1, 32'h14,  0};
    tbl[9] = '{0, 1, 1, 32'h103, 0, NOP,             32'h10, 0, 32'h100, 0};
    for (int i = 0; i < 10; i++) begin
      reset_stages   = tbl[i].rst;
      stall          = tbl[i].stl;
      redirect_valid = tbl[i].rdv;
      redirect_pc    = tbl[i].rpc;
      dbg_halt_req   = tbl[i].hlt;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_pco, tbl[i].e_v,
              tbl[i].e_addr, tbl[i].e_h);
    end
    idle();

    // Halt at 0x40, single step, then resume
    redirect_valid = 1; redirect_pc = 32'h40; tick(); idle();
    chk_all("redir40", NOP, 32'h10, 0, 32'h40, 0);
    dbg_halt_req = 1; tick(); idle();
    chk_all("halt", NOP, 32'h10, 0, 32'h40, 1);
    tick();
    chk_all("halted_hold", NOP, 32'h10, 0, 32'h40, 1);
    dbg_step_req = 1; tick(); idle();
    chk_all("step_enter", NOP, 32'h10, 0, 32'h40, 0);
    vcount = 0;
    tick();
    if (ir_valid) vcount++;
    chk_all("step_fetch", mem(32'h40), 32'h40, 1, 32'h44, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ir_valid) vcount++;
    end
    chk_all("step_after", NOP, 32'h40, 0, 32'h44, 1);
    chk("step_valid_count", vcount, 1);
    dbg_resume_req = 1; tick(); idle();
    chk_all("resume", NOP, 32'h40, 0, 32'h44, 0);
    tick();
    chk_all("run44", mem(32'h44), 32'h44, 1, 32'h48, 0);
    tick();
    chk_all("run48", mem(32'h48), 32'h48, 1, 32'h4C, 0);

    // Halt request is deferred while stalled
    stall = 1; dbg_halt_req = 1; tick();
    chk_all("halt_deferred", mem(32'h48), 32'h48, 1, 32'h4C, 0);
    stall = 0; tick(); idle();
    chk_all("halt_late", NOP, 32'h48, 0, 32'h4C, 1);

    // Reset while stuck in STEP under stall
    dbg_step_req = 1; tick(); idle();
    stall = 1; tick();
    chk_all("step_stalled", NOP, 32'h48, 0, 32'h4C, 0);
    reset_stages = 1; tick(); idle();
    chk_all("rst_in_step", NOP, 32'h0, 0, 32'h0, 0);
    tick();
    chk_all("post_rst", 32'h0050_0093, 32'h0, 1, 32'h4, 0);

    // PC wrap at the top of the address space
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE; tick(); idle();
    chk_all("redir_top", NOP, 32'h0, 0, 32'hFFFF_FFFC, 0);
    tick();
    chk_all("wrap", mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1, 32'h0, 0);

    // Halt and redirect together: halted PC is the redirect target
    dbg_halt_req = 1; redirect_valid = 1; redirect_pc = 32'h80; tick(); idle();
    chk_all("halt_redir", NOP, 32'hFFFF_FFFC, 0, 32'h80, 1);
    dbg_resume_req = 1; dbg_step_req = 1; tick(); idle();
    chk_all("resume_wins", NOP, 32'hFFFF_FFFC, 0, 32'h80, 0);
    tick();
    chk_all("run80", mem(32'h80), 32'h80, 1, 32'h84, 0);

`ifdef DBG_PC_WRITE_EN
    dbg_halt_req = 1; tick(); idle();
    dbg_pc_we = 1; dbg_pc_wdata = 32'h203; dbg_resume_req = 1; tick(); idle();
    chk_all("pcw_resume", NOP, 32'h80, 0, 32'h200, 0);
    tick();
    chk_all("pcw_fetch", mem(32'h200), 32'h200, 1, 32'h204, 0);
    dbg_pc_we = 1; dbg_pc_wdata = 32'h500; tick(); idle();
    chk_all("pcw_run_ignored", mem(32'h204), 32'h204, 1, 32'h208, 0);
`endif

    // Randomized run against the reference model
    reset_stages = 1;
    model_step(1'b0, 32'h0);
    tick();
    reset_stages = 0;
    for (int n = 0; n < 3000; n++) begin
      logic we;
      logic [31:0] wd;
      reset_stages   = ($urandom_range(0, 99) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      dbg_halt_req   = ($urandom_range(0, 11) == 0);
      dbg_resume_req = ($urandom_range(0, 9) == 0);
      dbg_step_req   = ($urandom_range(0, 5) == 0);
      dbg_pc_we      = ($urandom_range(0, 4) == 0);
      dbg_pc_wdata   = $urandom;
`ifdef DBG_PC_WRITE_EN
      we = dbg_pc_we;
`else
      we = 1'b0;
`endif
      wd = dbg_pc_wdata;
      model_step(we, wd);
      tick();
      chk_all($sformatf("rnd%0d", n), m_ir, m_pco, m_v, m_pc, (m_mode == 1));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
